// File: rtl/sram_fifo_ctrl_pkg.sv
// Shared constants and helpers for the SRAM-backed show-ahead FIFO controller.
// The output stage is a fixed two-entry queue, so its occupancy fits in two bits.
package sram_fifo_ctrl_pkg;

    localparam int OUT_DEPTH = 2;

    typedef logic [1:0] stage_count_t;

    // Occupancy the output stage will reach once this cycle's pop and SRAM return land.
    function automatic stage_count_t stage_after(
        input stage_count_t count,
        input logic         pending,
        input logic         pop
    );
        return stage_count_t'(count + stage_count_t'(pending) - stage_count_t'(pop));
    endfunction

endpackage

// File: rtl/sram_fifo_ctrl_out_stage.sv
// Two-entry in-order output queue that absorbs the SRAM read latency.
// Entry 0 is the head; a returning word lands behind whatever survives this cycle's pop.
module fifo_out_stage
    import sram_fifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  append_en,
    input  logic [DATA_WIDTH-1:0] append_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output stage_count_t          count
);

    logic [DATA_WIDTH-1:0] entries [OUT_DEPTH];
    logic                  do_pop;
    stage_count_t          append_pos;
    logic                  append_idx;

    assign do_pop     = pop && (count != 2'd0);
    assign append_pos = count - stage_count_t'(do_pop);
    assign append_idx = append_pos[0];
    assign head       = entries[0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= 2'd0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            count <= count + stage_count_t'(append_en) - stage_count_t'(do_pop);
        end
    end

    // NOTE: data entries carry no reset; count alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (!flush) begin
            if (do_pop) begin
                entries[0] <= entries[1];
            end
            // A same-cycle append to slot 0 after a pop must win over the shift.
            if (append_en) begin
                entries[append_idx] <= append_data;
            end
        end
    end

endmodule

// File: rtl/sram_fifo_ctrl.sv
// Show-ahead FIFO controller driving one write port and one read port of a synchronous SRAM.
// Owns pointers and occupancy; a two-entry output stage hides the one-cycle read latency.
module sram_fifo_ctrl
    import sram_fifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH            = 32,
    parameter int SIZE                  = 64,
    parameter int ALMOST_FULL_THRESHOLD = SIZE - 4,
    parameter int ADDR_WIDTH            = $clog2(SIZE)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  enqueue_en,
    input  logic [DATA_WIDTH-1:0] enqueue_value,
    output logic                  full,
    output logic                  almost_full,
    input  logic                  dequeue_en,
    output logic [DATA_WIDTH-1:0] dequeue_value,
    output logic                  empty,
    output logic                  sram_read_en,
    output logic [ADDR_WIDTH-1:0] sram_read_addr,
    input  logic [DATA_WIDTH-1:0] sram_read_data,
    output logic                  sram_write_en,
    output logic [ADDR_WIDTH-1:0] sram_write_addr,
    output logic [DATA_WIDTH-1:0] sram_write_data
);

    localparam logic [ADDR_WIDTH:0] SIZE_COUNT = (ADDR_WIDTH + 1)'(SIZE);
    localparam logic [ADDR_WIDTH:0] AF_COUNT   = (ADDR_WIDTH + 1)'(ALMOST_FULL_THRESHOLD);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   mem_count;
    logic                  read_pending;
    stage_count_t          out_count;
    stage_count_t          stage_next;
    logic                  active;
    logic                  deq;

    // Reset and flush both suppress every strobe so nothing leaks out while state clears.
    assign active = !reset && !flush;

    assign full        = (mem_count == SIZE_COUNT);
    assign almost_full = (mem_count >= AF_COUNT);
    assign empty       = (out_count == 2'd0);

    assign sram_write_en   = active && enqueue_en && !full;
    assign sram_write_addr = wr_ptr;
    assign sram_write_data = enqueue_value;

    assign deq            = active && dequeue_en && (out_count != 2'd0);
    assign stage_next     = stage_after(out_count, read_pending, deq);
    assign sram_read_en   = active && (mem_count != '0) && (stage_next <= 2'd1);
    assign sram_read_addr = rd_ptr;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            mem_count    <= '0;
            read_pending <= 1'b0;
        end else if (flush) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            mem_count    <= '0;
            read_pending <= 1'b0;
        end else begin
            wr_ptr       <= wr_ptr + ADDR_WIDTH'(sram_write_en);
            rd_ptr       <= rd_ptr + ADDR_WIDTH'(sram_read_en);
            mem_count    <= mem_count + (ADDR_WIDTH + 1)'(sram_write_en)
                                      - (ADDR_WIDTH + 1)'(sram_read_en);
            read_pending <= sram_read_en;
        end
    end

    fifo_out_stage #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_stage (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .append_en   (read_pending),
        .append_data (sram_read_data),
        .pop         (deq),
        .head        (dequeue_value),
        .count       (out_count)
    );

    enqueue_when_full : assert property (@(posedge clk) disable iff (reset || flush)
        !(enqueue_en && full))
        else $warning("enqueue while full dropped");

    dequeue_when_empty : assert property (@(posedge clk) disable iff (reset || flush)
        !(dequeue_en && empty))
        else $warning("dequeue while empty ignored");

    no_address_collision : assert property (@(posedge clk) disable iff (reset)
        !(sram_read_en && sram_write_en && (sram_read_addr == sram_write_addr)));

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Directed bench for sram_fifo_ctrl with a behavioural one-cycle-latency SRAM.
// A scoreboard queue holds the words expected at the head of the FIFO.
module tb_sram_fifo_ctrl;

    localparam int DW   = 32;
    localparam int SIZE = 64;
    localparam int AW   = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          enqueue_en;
    logic [DW-1:0] enqueue_value;
    logic          full;
    logic          almost_full;
    logic          dequeue_en;
    logic [DW-1:0] dequeue_value;
    logic          empty;
    logic          sram_read_en;
    logic [AW-1:0] sram_read_addr;
    logic [DW-1:0] sram_read_data;
    logic          sram_write_en;
    logic [AW-1:0] sram_write_addr;
    logic [DW-1:0] sram_write_data;

    logic [DW-1:0] sram_mem [SIZE];
    logic [DW-1:0] model [$];
    int            checks     = 0;
    int            passed     = 0;
    int            collisions = 0;

    always #5 clk = ~clk;

    sram_fifo_ctrl #(
        .DATA_WIDTH (DW),
        .SIZE       (SIZE)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .flush           (flush),
        .enqueue_en      (enqueue_en),
        .enqueue_value   (enqueue_value),
        .full            (full),
        .almost_full     (almost_full),
        .dequeue_en      (dequeue_en),
        .dequeue_value   (dequeue_value),
        .empty           (empty),
        .sram_read_en    (sram_read_en),
        .sram_read_addr  (sram_read_addr),
        .sram_read_data  (sram_read_data),
        .sram_write_en   (sram_write_en),
        .sram_write_addr (sram_write_addr),
        .sram_write_data (sram_write_data)
    );

    // Don't-care read-during-write: a colliding read returns garbage.
    always @(posedge clk) begin
        if (sram_write_en) sram_mem[sram_write_addr] <= sram_write_data;
        if (sram_read_en) begin
            if (sram_write_en && sram_read_addr == sram_write_addr) begin
                sram_read_data <= $urandom;
                collisions     <= collisions + 1;
            end else begin
                sram_read_data <= sram_mem[sram_read_addr];
            end
        end
    end

    task automatic check(input string tag, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
        checks++;
        if (actual !== expected)
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        else
            passed++;
    endtask

    // One clock cycle of stimulus; pops are checked against the scoreboard before the edge.
    task automatic tick(input logic enq, input logic [DW-1:0] val, input logic deq);
        enqueue_en    = enq;
        enqueue_value = val;
        dequeue_en    = deq;
        #1;
        if (deq && !empty) begin
            if (model.size() == 0) check("deq_unexpected", 1, 0);
            else                   check("deq_value", dequeue_value, model.pop_front());
        end
        if (enq && !full) model.push_back(val);
        @(posedge clk);
        #1;
        enqueue_en = 1'b0;
        dequeue_en = 1'b0;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && model.size() > 0; i++) tick(1'b0, '0, !empty);
        check("drain_left", model.size(), 0);
        check("drain_empty", empty, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int next_val;
        logic enq, deq;

        reset = 1'b1; flush = 1'b0;
        enqueue_en = 1'b1; dequeue_en = 1'b1; enqueue_value = 32'hFFFF_FFFF;
        #2;
        check("rst_empty", empty, 1'b1);
        check("rst_full", full, 1'b0);
        check("rst_almost_full", almost_full, 1'b0);
        check("rst_read_en", sram_read_en, 1'b0);
        check("rst_write_en", sram_write_en, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0; enqueue_en = 1'b0; dequeue_en = 1'b0;
        #1;
        check("idle_read_en", sram_read_en, 1'b0);

        // Single entry: visible on the third edge after the push.
        tick(1'b1, 32'hA5A5_0001, 1'b0);
        check("single_empty_c1", empty, 1'b1);
        tick(1'b0, '0, 1'b0);
        check("single_empty_c2", empty, 1'b1);
        tick(1'b0, '0, 1'b0);
        check("single_empty_c3", empty, 1'b0);
        check("single_value", dequeue_value, 32'hA5A5_0001);
        tick(1'b0, '0, 1'b1);
        check("single_pop_empty", empty, 1'b1);

        // Fill: two words go to the stage, 64 remain in SRAM.
        for (int n = 1; n <= 66; n++) begin
            tick(1'b1, DW'(n - 1), 1'b0);
            if (n == 61) check("af_below", almost_full, 1'b0);
            if (n == 62) check("af_at_60", almost_full, 1'b1);
            if (n == 65) check("full_at_63", full, 1'b0);
            if (n == 66) check("full_at_64", full, 1'b1);
        end
        check("fill_head", dequeue_value, 32'd0);
        check("fill_nonempty", empty, 1'b0);
        enqueue_en = 1'b1; enqueue_value = 32'd999;
        #1;
        check("drop_write_en", sram_write_en, 1'b0);
        tick(1'b1, 32'd999, 1'b0);
        check("drop_still_full", full, 1'b1);
        drain(300);

        // Streaming after a three-word prime.
        for (int i = 0; i < 3; i++) tick(1'b1, DW'(1000 + i), 1'b0);
        for (int i = 0; i < 1000; i++) begin
            check("stream_nonempty", empty, 1'b0);
            tick(1'b1, DW'(1003 + i), 1'b1);
        end
        drain(20);

        // Random gaps; several pointer wraps.
        next_val = 5000;
        for (int i = 0; i < 600; i++) begin
            enq = ($urandom_range(3) != 0) && !full;
            deq = ($urandom_range(3) != 0) && !empty;
            tick(enq, DW'(next_val), deq);
            if (enq) next_val++;
        end
        drain(400);

        // Flush while a read is in flight.
        tick(1'b1, 32'hDEAD_BEEF, 1'b0);
        check("flush_read_issue", sram_read_en, 1'b1);
        tick(1'b0, '0, 1'b0);
        flush = 1'b1;
        tick(1'b1, 32'h5555_5555, 1'b1);
        flush = 1'b0;
        model.delete();
        check("flush_empty", empty, 1'b1);
        check("flush_full", full, 1'b0);
        check("flush_read_en", sram_read_en, 1'b0);
        tick(1'b0, '0, 1'b0);
        check("flush_discard_1", empty, 1'b1);
        tick(1'b0, '0, 1'b0);
        check("flush_discard_2", empty, 1'b1);
        tick(1'b1, 32'h0000_1234, 1'b0);
        tick(1'b0, '0, 1'b0);
        tick(1'b0, '0, 1'b0);
        check("post_flush_value", dequeue_value, 32'h0000_1234);
        drain(5);

        // Asynchronous reset between edges in the middle of a stream.
        for (int i = 0; i < 3; i++) tick(1'b1, DW'(7000 + i), 1'b0);
        for (int i = 0; i < 5; i++) tick(1'b1, DW'(7003 + i), 1'b1);
        enqueue_en = 1'b1; dequeue_en = 1'b1; enqueue_value = 32'd7777;
        #3;
        reset = 1'b1;
        #1;
        check("async_rst_empty", empty, 1'b1);
        check("async_rst_full", full, 1'b0);
        check("async_rst_read_en", sram_read_en, 1'b0);
        check("async_rst_write_en", sram_write_en, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0; enqueue_en = 1'b0; dequeue_en = 1'b0;
        model.delete();
        for (int i = 0; i < 4; i++) tick(1'b1, DW'(8000 + i), 1'b0);
        tick(1'b0, '0, 1'b0);
        tick(1'b0, '0, 1'b0);
        check("resume_head", dequeue_value, 32'd8000);
        drain(20);

        check("no_collisions", collisions, 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
